// File: rtl/hog_frame_ctrl_pkg.sv
// hog_ctrl_pkg: shared definitions for the HOG frame sequencer.
//   - state_t      : frame sequencer states (3-bit encoding is visible in status)
//   - CMD_*        : bit positions within the 32-bit command PIO word
//   - STAT_*       : field LSB positions and widths within the 32-bit status word
package hog_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int unsigned CMD_START = 0;
  localparam int unsigned CMD_ABORT = 1;

  localparam int unsigned STAT_STATE_LSB   = 0;
  localparam int unsigned STAT_STATE_W     = 3;
  localparam int unsigned STAT_DONE_BIT    = 3;
  localparam int unsigned STAT_TIMEOUT_BIT = 4;
  localparam int unsigned STAT_OVF_BIT     = 5;
  localparam int unsigned STAT_PATH_BIT    = 6;
  localparam int unsigned STAT_FRAME_LSB   = 8;
  localparam int unsigned STAT_FRAME_W     = 8;
  localparam int unsigned STAT_DESC_LSB    = 16;
  localparam int unsigned STAT_DESC_W      = 16;

endpackage

// File: rtl/hog_skid_buffer.sv
// hog_skid_buffer: 2-entry valid/ready skid buffer with registered outputs.
// Only compiled when HOG_FRAME_CTRL_SKID_EN is defined (its sole user).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : synchronous discard of both entries
//   in_valid/in_ready/in_data    : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake (registered)
//   empty           : no entry held
`ifdef HOG_FRAME_CTRL_SKID_EN
module hog_skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);

  logic         sk_valid;
  logic [W-1:0] sk_data;

  assign in_ready = ~sk_valid;
  assign empty    = ~out_valid & ~sk_valid;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
    end else if (out_ready || !out_valid) begin
      if (sk_valid) begin
        out_valid <= 1'b1;
        out_data  <= sk_data;
        sk_valid  <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !sk_valid) begin
      // Output stalled: park the accepted beat in the second entry.
      sk_valid <= 1'b1;
      sk_data  <= in_data;
    end
  end

endmodule
`endif

// File: rtl/hog_frame_ctrl.sv
// hog_frame_ctrl: frame sequencer between the pixel source and the HOG core.
// Admits one frame per start command, then waits for the frame's descriptors
// on the HOG output handshake, with a drain watchdog. Status is registered.
// Optional macro HOG_FRAME_CTRL_SKID_EN inserts a registered 2-entry skid
// buffer on the pixel path (1-cycle latency); default is a combinational path.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   cmd_pio[31:0]                     : bit0 start (rising edge), bit1 abort (level)
//   src_valid/src_ready/src_pixel     : pixel source handshake
//   hog_in_valid/hog_in_ready/hog_in_pixel : HOG core input handshake
//   hog_out_valid/hog_out_ready       : HOG output handshake (observed only)
//   status_pio[31:0]                  : {desc_cnt, frame_cnt, 0, path_open, desc_ovf, timeout_err, done, state}
module hog_frame_ctrl #(
  parameter int unsigned FRAME_PIXELS   = 307200,
  parameter int unsigned DESC_PER_FRAME = 4661,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd_pio,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [7:0]  src_pixel,
  output logic        hog_in_valid,
  input  logic        hog_in_ready,
  output logic [7:0]  hog_in_pixel,
  input  logic        hog_out_valid,
  input  logic        hog_out_ready,
  output logic [31:0] status_pio
);
  import hog_ctrl_pkg::*;

  localparam int unsigned PIX_W  = $clog2(FRAME_PIXELS);
  localparam int unsigned DESC_W = $clog2(DESC_PER_FRAME + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES);

  state_t            state, state_next;
  logic              start_q;
  logic [PIX_W-1:0]  pix_cnt;
  logic [DESC_W-1:0] desc_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic [7:0]        frame_cnt;
  logic              timeout_err, desc_ovf;
  logic [31:0]       status_next;

  logic start_rise, abort, out_fire, pix_fire, pix_last, stream_end;
  logic desc_full, timeout_hit, streaming, restart;
  logic unused_cmd;

  assign start_rise  = cmd_pio[CMD_START] & ~start_q;
  assign abort       = cmd_pio[CMD_ABORT];
  assign out_fire    = hog_out_valid & hog_out_ready;
  assign streaming   = (state == ST_STREAM);
  assign pix_last    = (pix_cnt == PIX_W'(FRAME_PIXELS - 1));
  assign desc_full   = (desc_cnt == DESC_W'(DESC_PER_FRAME));
  assign timeout_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign restart     = start_rise && (state == ST_IDLE || state == ST_DONE);
  assign unused_cmd  = ^cmd_pio[31:2];

`ifdef HOG_FRAME_CTRL_SKID_EN
  logic src_last, skid_empty, skid_in_ready;

  // Pixels are counted on the source side; the frame only ends once the
  // last accepted pixel has left the buffer.
  assign src_ready  = skid_in_ready & streaming & ~src_last;
  assign pix_fire   = src_valid & src_ready;
  assign stream_end = src_last & skid_empty;

  hog_skid_buffer #(.W(8)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .in_valid  (pix_fire),
    .in_ready  (skid_in_ready),
    .in_data   (src_pixel),
    .out_valid (hog_in_valid),
    .out_ready (hog_in_ready),
    .out_data  (hog_in_pixel),
    .empty     (skid_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || abort || !streaming) src_last <= 1'b0;
    else if (pix_fire && pix_last)  src_last <= 1'b1;
  end
`else
  logic in_fire;

  assign hog_in_valid = streaming & src_valid;
  assign src_ready    = streaming & hog_in_ready;
  assign hog_in_pixel = streaming ? src_pixel : '0;
  assign in_fire      = hog_in_valid & hog_in_ready;
  assign pix_fire     = in_fire;
  assign stream_end   = in_fire & pix_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_rise) state_next = ST_STREAM;
      ST_STREAM: if (stream_end) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (desc_full)        state_next = ST_DONE;
        else if (timeout_hit) state_next = ST_ERROR;
      end
      ST_DONE:   if (start_rise) state_next = ST_STREAM;
      ST_ERROR:  state_next = ST_ERROR;
      default:   state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= 1'b1;
      pix_cnt     <= '0;
      desc_cnt    <= '0;
      wd_cnt      <= '0;
      frame_cnt   <= '0;
      timeout_err <= 1'b0;
      desc_ovf    <= 1'b0;
    end else begin
      start_q <= cmd_pio[CMD_START];
      if (abort) begin
        timeout_err <= 1'b0;
        desc_ovf    <= 1'b0;
      end else if (restart) begin
        pix_cnt  <= '0;
        desc_cnt <= '0;
        wd_cnt   <= '0;
        if (state == ST_IDLE) begin
          timeout_err <= 1'b0;
          desc_ovf    <= 1'b0;
        end
      end else begin
        if (streaming && pix_fire) pix_cnt <= pix_cnt + 1'b1;
        if (out_fire && (state == ST_STREAM || state == ST_DRAIN || state == ST_DONE)) begin
          if (desc_full) desc_ovf <= 1'b1;
          else           desc_cnt <= desc_cnt + 1'b1;
        end
        if (state == ST_DRAIN) begin
          if (desc_full) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
          end
        end
        if (state_next == ST_DONE && state != ST_DONE) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    status_next = '0;
    status_next[STAT_STATE_LSB +: STAT_STATE_W] = state;
    status_next[STAT_DONE_BIT]    = (state == ST_DONE);
    status_next[STAT_TIMEOUT_BIT] = timeout_err;
    status_next[STAT_OVF_BIT]     = desc_ovf;
    status_next[STAT_PATH_BIT]    = streaming;
    status_next[STAT_FRAME_LSB +: STAT_FRAME_W] = frame_cnt;
    status_next[STAT_DESC_LSB +: STAT_DESC_W]   = 16'(desc_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) status_pio <= '0;
    else     status_pio <= status_next;
  end

endmodule

// File: tb/tb_hog_frame_ctrl.sv
// tb_hog_frame_ctrl: randomized self-checking bench for hog_frame_ctrl with a
// small frame (16 pixels, 4 descriptors, 50-cycle drain watchdog).
module tb_hog_frame_ctrl;

  localparam int FP = 16;
  localparam int DP = 4;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_pio;
  logic        src_valid, src_ready;
  logic [7:0]  src_pixel;
  logic        hog_in_valid, hog_in_ready;
  logic [7:0]  hog_in_pixel;
  logic        hog_out_valid, hog_out_ready;
  logic [31:0] status_pio;

  int errors = 0;
  int checks = 0;
  int frames_done = 0;

  always #5 clk = ~clk;

  hog_frame_ctrl #(
    .FRAME_PIXELS   (FP),
    .DESC_PER_FRAME (DP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_pio       (cmd_pio),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_pixel     (src_pixel),
    .hog_in_valid  (hog_in_valid),
    .hog_in_ready  (hog_in_ready),
    .hog_in_pixel  (hog_in_pixel),
    .hog_out_valid (hog_out_valid),
    .hog_out_ready (hog_out_ready),
    .status_pio    (status_pio)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Status word assembled from its documented field layout.
  function automatic logic [31:0] exp_status(input int st, input bit ovf, input bit to,
                                             input int frame, input int desc);
    logic [31:0] w;
    w        = '0;
    w[2:0]   = st[2:0];
    w[3]     = (st == 3);
    w[4]     = to;
    w[5]     = ovf;
    w[6]     = (st == 1);
    w[15:8]  = frame[7:0];
    w[31:16] = desc[15:0];
    return w;
  endfunction

  // Stimulus only: feeds an ascending pixel frame until FP beats reach the
  // HOG input, then keeps offering pixels for 3 more cycles.
  task automatic drive_frame(input bit rnd, output int fires, output int accepted,
                             output bit timed_out);
    int cyc;
    bit sf, hf;
    fires = 0; accepted = 0; timed_out = 0; cyc = 0;
    src_valid = 1'b1;
    while (fires < FP) begin
      if (cyc >= 300) begin timed_out = 1'b1; break; end
      hog_in_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_pixel = 8'(accepted);
      #1;
      sf = src_valid & src_ready;
      hf = hog_in_valid & hog_in_ready;
      tick();
      if (sf) accepted++;
      if (hf) fires++;
      cyc++;
    end
    hog_in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_pixel = 8'(accepted);
      #1;
      sf = src_valid & src_ready;
      hf = hog_in_valid & hog_in_ready;
      tick();
      if (sf) accepted++;
      if (hf) fires++;
    end
    src_valid = 1'b0;
  endtask

  task automatic pulse_start();
    cmd_pio = 32'd0; tick();
    cmd_pio = 32'd1; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_pio = 32'd1;
    src_valid = 1'b1; src_pixel = 8'hAA; hog_in_ready = 1'b1;
    hog_out_valid = 1'b0; hog_out_ready = 1'b0;
    repeat (3) tick();
    checks++; if (status_pio !== 32'd0) begin errors++; $display("FAIL reset_status: got %h expected %h", status_pio, 32'd0); end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready: got %b expected 0", src_ready); end
    checks++; if (hog_in_valid !== 1'b0) begin errors++; $display("FAIL reset_hog_in_valid: got %b expected 0", hog_in_valid); end
    checks++; if (hog_in_pixel !== 8'h00) begin errors++; $display("FAIL reset_hog_in_pixel: got %h expected 00", hog_in_pixel); end
    src_valid = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (status_pio !== 32'd0) begin errors++; $display("FAIL held_start_idle: got %h expected %h", status_pio, 32'd0); end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL held_start_gated: got %b expected 0", src_ready); end
    pulse_start();
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL start_path_open: got %b expected 1", src_ready); end
    tick();
    checks++; if (status_pio !== exp_status(1, 0, 0, 0, 0)) begin errors++; $display("FAIL start_status: got %h expected %h", status_pio, exp_status(1, 0, 0, 0, 0)); end
  endtask

  task automatic test_stream_pixels();
    int sent, got, cyc;
    bit sf, hf;
    sent = 0; got = 0; cyc = 0;
    while (got < FP && cyc < 400) begin
      src_valid = 1'b1;
      src_pixel = 8'(sent);
      hog_in_ready = ($urandom_range(0, 3) != 0);
      #1;
      sf = src_valid & src_ready;
      hf = hog_in_valid & hog_in_ready;
      if (hf) begin
        checks++;
        if (hog_in_pixel !== 8'(got)) begin errors++; $display("FAIL pixel_data[%0d]: got %h expected %h", got, hog_in_pixel, 8'(got)); end
        got++;
      end
      tick();
      if (sf) sent++;
      cyc++;
    end
    checks++; if (got != FP) begin errors++; $display("FAIL pixel_budget: got %0d beats expected %0d", got, FP); end
    hog_in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_pixel = 8'(sent);
      #1;
      sf = src_valid & src_ready;
      tick();
      if (sf) sent++;
    end
    checks++; if (sent != FP) begin errors++; $display("FAIL src_accept_count: got %0d expected %0d", sent, FP); end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL src_gated_after_frame: got %b expected 0", src_ready); end
    checks++; if (hog_in_valid !== 1'b0) begin errors++; $display("FAIL hog_gated_after_frame: got %b expected 0", hog_in_valid); end
    checks++; if (status_pio[2:0] !== 3'd2) begin errors++; $display("FAIL drain_state: got %0d expected 2", status_pio[2:0]); end
    src_valid = 1'b0;
  endtask

  task automatic test_done();
    int fires, cyc;
    fires = 0; cyc = 0;
    while (fires < DP && cyc < 100) begin
      hog_out_valid = 1'b1;
      hog_out_ready = ($urandom_range(0, 1) != 0) || (cyc >= 8);
      tick();
      if (hog_out_valid && hog_out_ready) fires++;
      cyc++;
    end
    hog_out_valid = 1'b0; hog_out_ready = 1'b0;
    frames_done++;
    tick(); tick();
    checks++; if (status_pio !== exp_status(3, 0, 0, frames_done, DP)) begin errors++; $display("FAIL done_status: got %h expected %h", status_pio, exp_status(3, 0, 0, frames_done, DP)); end
    hog_out_valid = 1'b1; hog_out_ready = 1'b1;
    tick();
    hog_out_valid = 1'b0; hog_out_ready = 1'b0;
    tick(); tick();
    checks++; if (status_pio !== exp_status(3, 1, 0, frames_done, DP)) begin errors++; $display("FAIL desc_ovf_status: got %h expected %h", status_pio, exp_status(3, 1, 0, frames_done, DP)); end
  endtask

  task automatic test_timeout();
    int cyc;
    bit seen;
    pulse_start();
    tick();
    checks++; if (status_pio !== exp_status(1, 1, 0, frames_done, 0)) begin errors++; $display("FAIL restart_keeps_flags: got %h expected %h", status_pio, exp_status(1, 1, 0, frames_done, 0)); end
    src_valid = 1'b1; hog_in_ready = 1'b1;
    seen = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      src_pixel = 8'(cyc);
      tick();
      if (status_pio[2:0] == 3'd2) begin seen = 1; break; end
    end
    src_valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL drain_entry_wait: got state %0d expected 2", status_pio[2:0]); end
    // First status showing DRAIN is one cycle after entry.
    repeat (TO - 1) tick();
    checks++; if (status_pio[2:0] !== 3'd2) begin errors++; $display("FAIL drain_before_timeout: got %0d expected 2", status_pio[2:0]); end
    tick();
    checks++; if (status_pio !== exp_status(4, 1, 1, frames_done, 0)) begin errors++; $display("FAIL timeout_status: got %h expected %h", status_pio, exp_status(4, 1, 1, frames_done, 0)); end
    pulse_start();
    tick(); tick();
    checks++; if (status_pio[2:0] !== 3'd4) begin errors++; $display("FAIL start_ignored_in_error: got %0d expected 4", status_pio[2:0]); end
    cmd_pio = 32'd2; tick();
    cmd_pio = 32'd0; tick(); tick();
    checks++; if (status_pio !== exp_status(0, 0, 0, frames_done, 0)) begin errors++; $display("FAIL abort_from_error: got %h expected %h", status_pio, exp_status(0, 0, 0, frames_done, 0)); end
  endtask

  task automatic test_abort_mid_stream();
    int fires, acc, cyc;
    bit to, hf;
    pulse_start();
    cmd_pio = 32'd0;
    src_valid = 1'b1; hog_in_ready = 1'b1;
    fires = 0; cyc = 0;
    while (fires < 7 && cyc < 50) begin
      src_pixel = 8'(cyc);
      #1;
      hf = hog_in_valid & hog_in_ready;
      tick();
      if (hf) fires++;
      cyc++;
    end
    cmd_pio = 32'd3;
    tick();
    cmd_pio = 32'd0;
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL abort_src_gated: got %b expected 0", src_ready); end
    checks++; if (hog_in_valid !== 1'b0) begin errors++; $display("FAIL abort_hog_gated: got %b expected 0", hog_in_valid); end
    src_valid = 1'b0;
    tick(); tick();
    checks++; if (status_pio !== exp_status(0, 0, 0, frames_done, 0)) begin errors++; $display("FAIL abort_beats_start: got %h expected %h", status_pio, exp_status(0, 0, 0, frames_done, 0)); end
    cmd_pio = 32'd1; tick();
    drive_frame(1'b1, fires, acc, to);
    checks++; if (to || fires != FP) begin errors++; $display("FAIL restart_full_frame: got %0d beats expected %0d", fires, FP); end
    checks++; if (acc != FP) begin errors++; $display("FAIL restart_src_count: got %0d expected %0d", acc, FP); end
    hog_out_valid = 1'b1; hog_out_ready = 1'b1;
    repeat (DP) tick();
    hog_out_valid = 1'b0; hog_out_ready = 1'b0;
    frames_done++;
    tick(); tick();
    checks++; if (status_pio !== exp_status(3, 0, 0, frames_done, DP)) begin errors++; $display("FAIL restart_done: got %h expected %h", status_pio, exp_status(3, 0, 0, frames_done, DP)); end
  endtask

  task automatic test_frame_wrap();
    int fires, acc;
    bit to;
    while (frames_done < 256) begin
      pulse_start();
      drive_frame(1'b0, fires, acc, to);
      hog_out_valid = 1'b1; hog_out_ready = 1'b1;
      repeat (DP) tick();
      hog_out_valid = 1'b0; hog_out_ready = 1'b0;
      frames_done++;
      tick(); tick();
      checks++; if (status_pio !== exp_status(3, 0, 0, frames_done, DP)) begin errors++; $display("FAIL frame_%0d_done: got %h expected %h", frames_done, status_pio, exp_status(3, 0, 0, frames_done, DP)); end
    end
    checks++; if (status_pio[15:8] !== 8'h00) begin errors++; $display("FAIL frame_cnt_wrap: got %h expected 00", status_pio[15:8]); end
  endtask

  initial begin
    test_reset();
    test_stream_pixels();
    test_done();
    test_timeout();
    test_abort_mid_stream();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
